// File: rtl/synth_pkg.sv
// Shared constants for the synth note path: state encoding, note word width,
// rest value, default beat length and the note dividers the player also uses.
package synth_pkg;

    localparam int NOTE_W = 16;
    localparam int BEAT_DIV_DEF = 12500000;

    localparam logic [NOTE_W-1:0] REST = 16'd0;

    // Half-period dividers of a 50 MHz clock, fifth octave
    localparam logic [NOTE_W-1:0] NOTE_C5 = 16'd47801;
    localparam logic [NOTE_W-1:0] NOTE_D5 = 16'd42588;
    localparam logic [NOTE_W-1:0] NOTE_E5 = 16'd37936;
    localparam logic [NOTE_W-1:0] NOTE_F5 = 16'd35817;
    localparam logic [NOTE_W-1:0] NOTE_G5 = 16'd31888;
    localparam logic [NOTE_W-1:0] NOTE_A5 = 16'd28409;
    localparam logic [NOTE_W-1:0] NOTE_B5 = 16'd25310;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2
    } state_t;

endpackage

// File: rtl/note_recorder_if.sv
// Control/status bundle between the keyboard mux, the recorder and the tone path.
// master drives requests and notein; slave (the recorder) drives the rest.
interface note_recorder_if #(
    parameter int NOTE_W = 16,
    parameter int ADDR_W = 6
);
    logic              rec_req;
    logic              play_req;
    logic              stop_req;
    logic [NOTE_W-1:0] notein;
    logic [NOTE_W-1:0] noteout;
    logic [1:0]        state_out;
    logic [ADDR_W-1:0] slot;
    logic [ADDR_W:0]   len;
    logic              busy;

    modport master (
        output rec_req, play_req, stop_req, notein,
        input  noteout, state_out, slot, len, busy
    );

    modport slave (
        input  rec_req, play_req, stop_req, notein,
        output noteout, state_out, slot, len, busy
    );
endinterface

// File: rtl/note_recorder_beat_tick_gen.sv
// Beat slot timer: counts 0..BEAT_DIV-1 and pulses tick on the last count.
// Ports: clk50, reset (async high), clr (restart at 0), tick (one cycle).
module beat_tick_gen #(
    parameter int BEAT_DIV = synth_pkg::BEAT_DIV_DEF
) (
    input  logic clk50,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = $clog2(BEAT_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CNT_W'(BEAT_DIV - 1));
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/note_recorder.sv
// Live note recorder: captures notein into a song RAM one slot per beat and
// loops it back out on noteout. Ports: clk50, reset (async high), bus (slave).
module note_recorder #(
    parameter int BEAT_DIV = synth_pkg::BEAT_DIV_DEF,
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = 6,
    parameter int NOTE_W   = synth_pkg::NOTE_W
) (
    input  logic            clk50,
    input  logic            reset,
    note_recorder_if.slave  bus
);
    import synth_pkg::*;

    localparam int LEN_W = ADDR_W + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] slot_q, slot_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [NOTE_W-1:0] noteout_q, noteout_d;
    logic              upd_q, upd_d;
    logic [NOTE_W-1:0] rd_q;
    logic [NOTE_W-1:0] mem [DEPTH];
    logic              tick;
    logic              clr;
    logic              we;

    beat_tick_gen #(.BEAT_DIV(BEAT_DIV)) u_tick (
        .clk50 (clk50),
        .reset (reset),
        .clr   (clr),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        len_d   = len_q;
        we      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.rec_req) begin
                    state_d = ST_RECORD;
                    slot_d  = '0;
                    len_d   = '0;
                end else if (bus.play_req && len_q != '0) begin
                    state_d = ST_PLAY;
                    slot_d  = '0;
                end
            end
            ST_RECORD: begin
                if (bus.stop_req) begin
                    state_d = ST_IDLE;
                    slot_d  = '0;
                end else if (tick) begin
                    we    = 1'b1;
                    len_d = {1'b0, slot_q} + LEN_W'(1);
                    if (slot_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = ST_IDLE;
                        slot_d  = '0;
                    end else begin
                        slot_d = slot_q + ADDR_W'(1);
                    end
                end
            end
            ST_PLAY: begin
                if (bus.stop_req) begin
                    state_d = ST_IDLE;
                    slot_d  = '0;
                end else if (tick) begin
                    if ({1'b0, slot_q} == len_q - LEN_W'(1)) begin
                        slot_d = '0;
                    end else begin
                        slot_d = slot_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                slot_d  = '0;
            end
        endcase

        clr = (state_d != state_q);
        // rd_q lags slot by one edge; upd_q marks that it is still stale
        upd_d = clr || (slot_d != slot_q);

        if (state_d == ST_IDLE) begin
            noteout_d = NOTE_W'(REST);
        end else if (state_d == ST_RECORD) begin
            noteout_d = bus.notein;
        end else if (state_q == ST_PLAY && !upd_q) begin
            noteout_d = rd_q;
        end else begin
            noteout_d = noteout_q;
        end
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            slot_q    <= '0;
            len_q     <= '0;
            noteout_q <= '0;
            upd_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            len_q     <= len_d;
            noteout_q <= noteout_d;
            upd_q     <= upd_d;
        end
    end

    always_ff @(posedge clk50) begin
        if (we) begin
            mem[slot_q] <= bus.notein;
        end
        rd_q <= mem[slot_q];
    end

    assign bus.noteout   = noteout_q;
    assign bus.state_out = state_q;
    assign bus.slot      = slot_q;
    assign bus.len       = len_q;
    assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder with BEAT_DIV=4, DEPTH=8.
// Table of per-cycle vectors plus hand-written multi-cycle sequences.
module tb_note_recorder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    note_recorder_if #(.NOTE_W(16), .ADDR_W(3)) bus ();

    note_recorder #(
        .BEAT_DIV (4),
        .DEPTH    (8),
        .ADDR_W   (3),
        .NOTE_W   (16)
    ) dut (
        .clk50 (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        rec;
        logic        play;
        logic        stop;
        logic [15:0] nin;
        logic [1:0]  st;
        logic [2:0]  sl;
        logic [3:0]  ln;
        logic [15:0] out;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic r, logic p, logic s, logic [15:0] n,
                                logic [1:0] st, logic [2:0] sl,
                                logic [3:0] ln, logic [15:0] o);
        vec_t v;
        v.rec = r; v.play = p; v.stop = s; v.nin = n;
        v.st = st; v.sl = sl; v.ln = ln; v.out = o;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic [1:0] st, logic [2:0] sl,
                           logic [3:0] ln, logic [15:0] o);
        chk({tag, ".state"}, 32'(bus.state_out), 32'(st));
        chk({tag, ".slot"}, 32'(bus.slot), 32'(sl));
        chk({tag, ".len"}, 32'(bus.len), 32'(ln));
        chk({tag, ".noteout"}, 32'(bus.noteout), 32'(o));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(st != 2'd0));
    endtask

    task automatic drive(logic r, logic p, logic s, logic [15:0] n);
        bus.rec_req  = r;
        bus.play_req = p;
        bus.stop_req = s;
        bus.notein   = n;
    endtask

    task automatic step(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        drive(0, 0, 0, 16'h0);

        // rows: inputs before edge, outputs expected after it
        tv.push_back(mk(0,1,0,16'h0000, 0,0,0,16'h0000));
        tv.push_back(mk(1,0,0,16'h1111, 1,0,0,16'h1111));
        tv.push_back(mk(0,0,0,16'h1111, 1,0,0,16'h1111));
        tv.push_back(mk(0,0,0,16'h1111, 1,0,0,16'h1111));
        tv.push_back(mk(0,0,0,16'h1111, 1,0,0,16'h1111));
        tv.push_back(mk(0,0,0,16'h1111, 1,1,1,16'h1111));
        tv.push_back(mk(0,0,0,16'h2222, 1,1,1,16'h2222));
        tv.push_back(mk(0,0,0,16'h2222, 1,1,1,16'h2222));
        tv.push_back(mk(0,0,0,16'h2222, 1,1,1,16'h2222));
        tv.push_back(mk(0,0,0,16'h2222, 1,2,2,16'h2222));
        tv.push_back(mk(0,0,0,16'h3333, 1,2,2,16'h3333));
        tv.push_back(mk(0,0,0,16'h3333, 1,2,2,16'h3333));
        tv.push_back(mk(0,0,0,16'h3333, 1,2,2,16'h3333));
        tv.push_back(mk(0,0,0,16'h3333, 1,3,3,16'h3333));
        tv.push_back(mk(0,0,0,16'h4444, 1,3,3,16'h4444));
        tv.push_back(mk(0,0,1,16'h4444, 0,0,3,16'h0000));
        tv.push_back(mk(0,1,0,16'h0000, 2,0,3,16'h0000));
        tv.push_back(mk(0,0,0,16'h0000, 2,0,3,16'h0000));
        tv.push_back(mk(0,0,0,16'h0000, 2,0,3,16'h1111));
        tv.push_back(mk(0,0,0,16'h0000, 2,0,3,16'h1111));
        tv.push_back(mk(0,0,0,16'h0000, 2,1,3,16'h1111));
        tv.push_back(mk(0,0,0,16'h0000, 2,1,3,16'h1111));
        tv.push_back(mk(0,0,0,16'h0000, 2,1,3,16'h2222));
        tv.push_back(mk(1,0,0,16'h0000, 2,1,3,16'h2222));
        tv.push_back(mk(0,0,0,16'h0000, 2,2,3,16'h2222));
        tv.push_back(mk(0,0,0,16'h0000, 2,2,3,16'h2222));
        tv.push_back(mk(0,0,0,16'h0000, 2,2,3,16'h3333));
        tv.push_back(mk(0,1,0,16'h0000, 2,2,3,16'h3333));
        tv.push_back(mk(0,0,0,16'h0000, 2,0,3,16'h3333));
        tv.push_back(mk(0,0,0,16'h0000, 2,0,3,16'h3333));
        tv.push_back(mk(0,0,0,16'h0000, 2,0,3,16'h1111));
        tv.push_back(mk(0,0,1,16'h0000, 0,0,3,16'h0000));

        // reset state
        step(2);
        chk_all("reset", 0, 0, 0, 16'h0);
        rst = 1'b0;

        foreach (tv[i]) begin
            drive(tv[i].rec, tv[i].play, tv[i].stop, tv[i].nin);
            step(1);
            chk_all($sformatf("row%0d", i), tv[i].st, tv[i].sl,
                    tv[i].ln, tv[i].out);
        end

        // stop coinciding with tick: one slot written, second not
        drive(1, 0, 0, 16'h5555);
        step(1);
        drive(0, 0, 0, 16'h5555);
        step(4);
        chk_all("rec1", 1, 1, 1, 16'h5555);
        drive(0, 0, 0, 16'h6666);
        step(3);
        chk_all("pretick", 1, 1, 1, 16'h6666);
        drive(0, 0, 1, 16'h6666);
        step(1);
        chk_all("stoptick", 0, 0, 1, 16'h0000);

        // single-slot loop keeps slot at 0
        drive(0, 1, 0, 16'h0);
        step(1);
        drive(0, 0, 0, 16'h0);
        step(2);
        chk_all("len1.play", 2, 0, 1, 16'h5555);
        step(2);
        chk_all("len1.wrap", 2, 0, 1, 16'h5555);
        drive(0, 0, 1, 16'h0);
        step(1);
        chk_all("len1.stop", 0, 0, 1, 16'h0000);

        // full take auto-stops on the eighth tick
        drive(1, 0, 0, 16'hABCD);
        step(1);
        drive(0, 0, 0, 16'hABCD);
        step(28);
        chk_all("full.s7", 1, 7, 7, 16'hABCD);
        step(3);
        chk_all("full.last", 1, 7, 7, 16'hABCD);
        step(1);
        chk_all("full.done", 0, 0, 8, 16'h0000);

        // play, then reset asynchronously at slot 1
        drive(0, 1, 0, 16'h0);
        step(1);
        drive(0, 0, 0, 16'h0);
        step(2);
        chk_all("full.play", 2, 0, 8, 16'hABCD);
        step(2);
        chk_all("full.slot1", 2, 1, 8, 16'hABCD);
        rst = 1'b1;
        #1;
        chk_all("async", 0, 0, 0, 16'h0000);
        #1;
        rst = 1'b0;
        drive(0, 1, 0, 16'h0);
        step(1);
        chk_all("postrst.play", 0, 0, 0, 16'h0000);
        drive(0, 0, 0, 16'h0);
        step(1);
        chk_all("postrst.idle", 0, 0, 0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_recorder.md
Name: note_recorder

Overview:
- Live-record counterpart to the song ROM player.
- Captures the 16-bit note word from the keyboard path into an internal song RAM, one sample per beat slot.
- Replays the stored slots in a loop on the same 16-bit note-word interface the tone path already consumes.
- Sits between the keyboard note mux and the tone generator. The note word is a 16-bit divider value; 16'd0 means rest/silence.

Parameters:
- BEAT_DIV, 12500000, clk50 cycles per beat slot (8th note at 120 bpm); must be >= 2.
- DEPTH, 64, number of note slots in the song RAM.
- ADDR_W, 6, slot address width; must equal clog2(DEPTH).
- NOTE_W, 16, note word width.

Ports:
- clk50  in  1  system clock, 50 MHz
- reset  in  1  asynchronous reset, active-high
- rec_req  in  1  one-cycle pulse: start recording
- play_req  in  1  one-cycle pulse: start looped playback
- stop_req  in  1  one-cycle pulse: return to idle
- notein  in  NOTE_W  live note word from the keyboard mux
- noteout  out  NOTE_W  note word to the tone generator (registered)
- state_out  out  2  current state: 0 IDLE, 1 RECORD, 2 PLAY
- slot  out  ADDR_W  current slot index
- len  out  ADDR_W+1  number of valid recorded slots, 0..DEPTH
- busy  out  1  high when state is not IDLE

Behaviour:
- Reset (async, active-high):
  - state IDLE; slot, len, beat counter and noteout all 0; busy 0.
  - RAM contents are not cleared; len=0 makes them unreachable.
- Beat tick:
  - The counter runs 0..BEAT_DIV-1. tick is asserted for one cycle when the count equals BEAT_DIV-1, and the counter then wraps to 0.
  - The counter is forced to 0 on every state transition, so the first slot in a new state lasts exactly BEAT_DIV cycles.
- Request priority: stop_req > rec_req > play_req.
  - rec_req and play_req are ignored while busy.
  - stop_req in IDLE is a no-op.
- IDLE:
  - noteout = 0.
  - rec_req: go to RECORD; slot=0, len=0.
  - play_req with len>0: go to PLAY; slot=0.
  - play_req with len==0: ignored, stay in IDLE.
- RECORD:
  - noteout = notein, registered with 1-cycle latency (monitor passthrough).
  - On tick: mem[slot] <= notein sampled in the tick cycle; len <= slot+1; slot increments.
  - Tick while slot==DEPTH-1: write, set len=DEPTH, go to IDLE, slot=0 (full auto-stop, no wrap).
  - stop_req: go to IDLE. If stop_req and tick fall in the same cycle, stop wins and there is no write. len keeps the slots already written; slot=0.
- PLAY:
  - RAM read is synchronous.
  - noteout = mem[slot], valid 2 cycles after slot changes, including entry from IDLE. During those 2 cycles noteout holds its previous value (0 on entry).
  - On tick: slot increments. Tick while slot==len-1 wraps slot to 0 (seamless loop).
  - stop_req: go to IDLE; noteout = 0 on the next cycle.
- Width rules:
  - len is ADDR_W+1 bits so DEPTH is representable.
  - slot arithmetic is modulo DEPTH, but wrap is governed by len in PLAY and by the full rule in RECORD.
- Reset mid-operation: immediate return to reset values. A partially recorded take is discarded because len=0.

Decomposition:
- Shared package (synth_pkg):
  - state encoding ST_IDLE/ST_RECORD/ST_PLAY
  - NOTE_W
  - REST = 16'd0
  - default BEAT_DIV
  - the note-word constants the player also uses
- One sub-module: beat_tick_gen.
  - Parameterised by BEAT_DIV.
  - Inputs: clk50, reset, clr.
  - Output: one-cycle tick.
  - Reusable to replace the player's divided-clock counter.
- The RAM is inferred inside note_recorder: single write port, single synchronous read port.

Test Plan (sim with BEAT_DIV=4, DEPTH=8):
- Reset, then play_req -> state stays 0, noteout=0, len=0.
- rec_req; notein=16'h1111/2222/3333 held across successive slots; stop_req mid 4th slot -> len=3, state 0, mem[0..2]=1111/2222/3333.
- play_req after the previous case -> noteout sequence 1111,2222,3333,1111,… Each value is held 4 cycles; first valid 2 cycles after entry; wrap occurs on the tick at slot 2.
- rec_req with a constant notein=16'hABCD for 8 ticks -> auto IDLE on the 8th tick, len=8, slot=0, busy=0.
- In RECORD, stop_req in the same cycle as tick -> no write, len unchanged. rec_req/play_req pulses during PLAY -> ignored, slot sequence undisturbed.
- Assert reset mid-PLAY at slot 1 -> same-cycle async clear: noteout=0, state 0, len=0. A subsequent play_req is ignored.
